// File: rtl/multitap_keypad_scanner.sv
// Column-scanned keypad with frame debounce and multi-tap A-Z entry; AUTO_COMMIT_EN commits on tap timeout.
// FSM outputs register one cycle after a debounced press; no backpressure, strobes are single-cycle.
module multitap_keypad_scanner #(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int SCAN_DIV        = 100,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int TAP_TIMEOUT     = 300,
    parameter int SUBMIT_KEY      = 12,
    parameter int CLEAR_KEY       = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [7:0]          letter,
    output logic                letter_pending,
    output logic [7:0]          char_out,
    output logic                char_valid,
    output logic                clear_pulse,
    output logic                multi_err
);
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int KW       = $clog2(NUM_KEYS + 1);
    localparam int DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int DEB_W    = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int TW       = $clog2(TAP_TIMEOUT + 1);
    localparam logic [KW-1:0] NONE = KW'(NUM_KEYS);

    typedef enum logic {IDLE, TAP} state_t;

    logic [DIV_W-1:0] div_cnt;
    logic [COL_W-1:0] col_idx;
    logic             slot_end, frame_end;
    logic [1:0]       acc_hits, slot_hits, tot_hits;
    logic [2:0]       hit_sum;
    logic [KW-1:0]    acc_key, slot_key, tot_key, frame_res;
    logic [KW-1:0]    cand, stable, press_key, cur_key, cur_key_n;
    logic [DEB_W-1:0] cand_cnt, deb_next;
    logic             press_vld;

    state_t           state, state_n;
    logic [7:0]       letter_n, char_out_n, base_ch;
    logic [1:0]       tap_idx, tap_idx_n, idx_next, size_m1;
    logic [TW-1:0]    tmo_cnt, tmo_n;
    logic             char_valid_n, clear_n, timed_out, is_letter;
    int               grp;

    assign slot_end  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_end = slot_end && (col_idx == COL_W'(NUM_COLS - 1));

    always_comb begin
        col_out          = '0;
        col_out[col_idx] = 1'b1;
    end

    // Hit count saturates at 2: only "none / one / several" matters per frame.
    always_comb begin
        slot_hits = 2'd0;
        slot_key  = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_in[r]) begin
                if (slot_hits != 2'd2) slot_hits = slot_hits + 2'd1;
                slot_key = KW'(r * NUM_COLS) + KW'(col_idx);
            end
        end
        hit_sum  = {1'b0, acc_hits} + {1'b0, slot_hits};
        tot_hits = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
        tot_key  = (slot_hits != 2'd0) ? slot_key : acc_key;
        frame_res = (tot_hits == 2'd1) ? tot_key : NONE;
        if (frame_res == cand)
            deb_next = (cand_cnt == DEB_W'(DEBOUNCE_FRAMES)) ? cand_cnt : cand_cnt + 1'b1;
        else
            deb_next = DEB_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            col_idx   <= '0;
            acc_hits  <= 2'd0;
            acc_key   <= '0;
            multi_err <= 1'b0;
            cand      <= NONE;
            cand_cnt  <= '0;
            stable    <= NONE;
            press_vld <= 1'b0;
            press_key <= NONE;
        end else begin
            press_vld <= 1'b0;
            if (slot_end) begin
                div_cnt <= '0;
                col_idx <= frame_end ? '0 : col_idx + 1'b1;
                if (frame_end) begin
                    acc_hits  <= 2'd0;
                    acc_key   <= '0;
                    multi_err <= (tot_hits == 2'd2);
                    cand      <= frame_res;
                    cand_cnt  <= deb_next;
                    if (deb_next >= DEB_W'(DEBOUNCE_FRAMES) && frame_res != stable) begin
                        stable    <= frame_res;
                        press_vld <= (frame_res != NONE);
                        press_key <= frame_res;
                    end
                end else begin
                    acc_hits <= tot_hits;
                    acc_key  <= tot_key;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Letter group: key index minus the special keys that precede it.
    always_comb begin
        grp = int'(press_key);
        if (int'(press_key) > SUBMIT_KEY) grp = grp - 1;
        if (int'(press_key) > CLEAR_KEY) grp = grp - 1;
        is_letter = (int'(press_key) != SUBMIT_KEY) && (int'(press_key) != CLEAR_KEY) &&
                    (int'(press_key) < NUM_KEYS) && (grp <= 8);
        base_ch   = 8'(65 + 3 * grp);
        size_m1   = (grp == 8) ? 2'd1 : 2'd2;
        idx_next  = (tap_idx == size_m1) ? 2'd0 : tap_idx + 2'd1;
    end

    always_comb begin
        state_n      = state;
        letter_n     = letter;
        tap_idx_n    = tap_idx;
        cur_key_n    = cur_key;
        tmo_n        = tmo_cnt;
        char_out_n   = 8'h00;
        char_valid_n = 1'b0;
        clear_n      = 1'b0;
        timed_out    = (tmo_cnt == TW'(TAP_TIMEOUT));
        if (state == TAP && !timed_out) tmo_n = tmo_cnt + 1'b1;
        if (press_vld) tmo_n = '0;

        if (press_vld && int'(press_key) == CLEAR_KEY) begin
            clear_n   = 1'b1;
            state_n   = IDLE;
            letter_n  = 8'h00;
            tap_idx_n = 2'd0;
        end else if (press_vld && int'(press_key) == SUBMIT_KEY) begin
            if (state == TAP) begin
                char_out_n   = letter;
                char_valid_n = 1'b1;
                state_n      = IDLE;
                letter_n     = 8'h00;
                tap_idx_n    = 2'd0;
            end
        end else if (press_vld && is_letter) begin
            if (state == TAP && press_key == cur_key && !timed_out) begin
                tap_idx_n = idx_next;
                letter_n  = base_ch + {6'd0, idx_next};
            end else begin
                state_n   = TAP;
                letter_n  = base_ch;
                tap_idx_n = 2'd0;
                cur_key_n = press_key;
            end
        end
`ifdef AUTO_COMMIT_EN
        else if (state == TAP && timed_out) begin
            char_out_n   = letter;
            char_valid_n = 1'b1;
            state_n      = IDLE;
            letter_n     = 8'h00;
            tap_idx_n    = 2'd0;
        end
`endif
        if (state_n == IDLE) tmo_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            letter      <= 8'h00;
            tap_idx     <= 2'd0;
            cur_key     <= NONE;
            tmo_cnt     <= '0;
            char_out    <= 8'h00;
            char_valid  <= 1'b0;
            clear_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            letter      <= letter_n;
            tap_idx     <= tap_idx_n;
            cur_key     <= cur_key_n;
            tmo_cnt     <= tmo_n;
            char_out    <= char_out_n;
            char_valid  <= char_valid_n;
            clear_pulse <= clear_n;
        end
    end

    assign letter_pending = (state == TAP);
endmodule

// File: tb/tb_multitap_keypad_scanner.sv
// Directed bench for multitap_keypad_scanner: 4x4 matrix, SCAN_DIV=2, DEBOUNCE_FRAMES=2, TAP_TIMEOUT=50.
module tb_multitap_keypad_scanner;
    localparam int NR = 4;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] row_in;
    logic [NC-1:0] col_out;
    logic [7:0]    letter, char_out;
    logic          letter_pending, char_valid, clear_pulse, multi_err;
    logic [15:0]   pressed;

    int checks = 0;
    int errors = 0;
    int cv_cnt = 0;
    int clr_cnt = 0;
    int multi_cnt = 0;
    logic [7:0] last_char = 8'h00;
    int c0, k0, m0;

    multitap_keypad_scanner #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .SCAN_DIV(2), .DEBOUNCE_FRAMES(2),
        .TAP_TIMEOUT(50), .SUBMIT_KEY(12), .CLEAR_KEY(15)
    ) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .letter(letter), .letter_pending(letter_pending), .char_out(char_out),
        .char_valid(char_valid), .clear_pulse(clear_pulse), .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    // Matrix model: a row senses a key only while that key's column is driven.
    always_comb begin
        row_in = '0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                if (col_out[c] && pressed[r*NC+c]) row_in[r] = 1'b1;
    end

    always @(negedge clk) begin
        if (char_valid) begin
            cv_cnt = cv_cnt + 1;
            last_char = char_out;
        end
        if (clear_pulse) clr_cnt = clr_cnt + 1;
        if (multi_err) multi_cnt = multi_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Two frames held, two frames released: exactly two samples of the key's column each way.
    task automatic tap(input int k);
        pressed[k] = 1'b1;
        cycles(16);
        pressed = '0;
        cycles(16);
    endtask

    initial begin
        rst = 1'b1;
        pressed = '0;
        cycles(2);
        check("rst_col_out", col_out, 4'b0001);
        check("rst_letter", letter, 8'h00);
        check("rst_pending", letter_pending, 1'b0);
        check("rst_char_out", char_out, 8'h00);
        check("rst_char_valid", char_valid, 1'b0);
        check("rst_clear", clear_pulse, 1'b0);
        check("rst_multi_err", multi_err, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cycles(2);
            check($sformatf("col_step%0d", i), col_out, 32'(1 << (i % 4)));
        end

        // One-frame glitch on key0 must not register
        pressed[0] = 1'b1;
        cycles(8);
        pressed = '0;
        cycles(24);
        check("glitch_pending", letter_pending, 1'b0);
        check("glitch_letter", letter, 8'h00);

        // Keys 0 and 4 together
        m0 = multi_cnt;
        c0 = cv_cnt;
        pressed[0] = 1'b1;
        pressed[4] = 1'b1;
        cycles(24);
        check("multi_err_high", multi_err, 1'b1);
        pressed = '0;
        cycles(16);
        check("multi_err_low", multi_err, 1'b0);
        check("multi_seen", 32'(multi_cnt > m0), 1);
        check("multi_pending", letter_pending, 1'b0);
        check("multi_no_char", cv_cnt - c0, 0);

        // Triple tap on key5 then submit
        tap(5);
        check("tap5_1", letter, 8'h50);
        check("tap5_pending", letter_pending, 1'b1);
        tap(5);
        check("tap5_2", letter, 8'h51);
        tap(5);
        check("tap5_3", letter, 8'h52);
        c0 = cv_cnt;
        tap(12);
        check("submit_count", cv_cnt - c0, 1);
        check("submit_char", last_char, 8'h52);
        check("submit_pending", letter_pending, 1'b0);
        check("submit_letter", letter, 8'h00);

        // Submit with nothing pending
        c0 = cv_cnt;
        tap(12);
        check("idle_submit", cv_cnt - c0, 0);
        check("idle_submit_pending", letter_pending, 1'b0);

        // Wrap on key0 then clear
        tap(0);
        check("wrap_1", letter, 8'h41);
        tap(0);
        check("wrap_2", letter, 8'h42);
        tap(0);
        check("wrap_3", letter, 8'h43);
        tap(0);
        check("wrap_4", letter, 8'h41);
        c0 = cv_cnt;
        k0 = clr_cnt;
        tap(15);
        check("clear_count", clr_cnt - k0, 1);
        check("clear_letter", letter, 8'h00);
        check("clear_pending", letter_pending, 1'b0);
        check("clear_no_char", cv_cnt - c0, 0);

        // Tap timeout on key4
        c0 = cv_cnt;
        tap(4);
        check("tmo_first", letter, 8'h4D);
        cycles(60);
`ifdef AUTO_COMMIT_EN
        check("tmo_auto_count", cv_cnt - c0, 1);
        check("tmo_auto_char", last_char, 8'h4D);
        check("tmo_auto_pending", letter_pending, 1'b0);
`else
        check("tmo_count", cv_cnt - c0, 0);
        check("tmo_letter", letter, 8'h4D);
        check("tmo_pending", letter_pending, 1'b1);
`endif
        tap(4);
        check("tmo_restart", letter, 8'h4D);
        tap(4);
        check("tmo_next", letter, 8'h4E);

        // Two-letter group on key8, then replacement by another key
        tap(8);
        check("yz_1", letter, 8'h59);
        tap(8);
        check("yz_2", letter, 8'h5A);
        tap(8);
        check("yz_wrap", letter, 8'h59);
        tap(5);
        check("replace", letter, 8'h50);
        k0 = clr_cnt;
        tap(15);
        check("final_clear", clr_cnt - k0, 1);
        check("final_pending", letter_pending, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
